// File: rtl/pkt_merge_arb.sv
// Packet-granular round-robin merge of two input FIFOs onto one registered output.
// Optional saturating packet/stray counters when PKT_MERGE_STATS_EN is defined.
module pkt_merge_arb #(
  parameter int DW      = 153,
  parameter int SOP_BIT = 152,
  parameter int EOP_BIT = 151
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in0_data,
  input  logic          in0_valid,
  output logic          in0_deq,
  input  logic [DW-1:0] in1_data,
  input  logic          in1_valid,
  output logic          in1_deq,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
`ifdef PKT_MERGE_STATS_EN
  output logic [15:0]   pkt_cnt0,
  output logic [15:0]   pkt_cnt1,
  output logic [15:0]   stray_cnt,
`endif
  output logic          err_stray
);

  typedef enum logic [1:0] {IDLE, FWD0, FWD1} state_t;

  state_t        state;
  logic          last_grant;
  logic          space, elig0, elig1, grant_port;
  logic          xfer, sel_port, stray0, stray1;
  logic [DW-1:0] sel_data;

  always_comb begin
    xfer       = 1'b0;
    sel_port   = 1'b0;
    stray0     = 1'b0;
    stray1     = 1'b0;
    space      = !out_valid || out_ready;
    elig0      = in0_valid && in0_data[SOP_BIT];
    elig1      = in1_valid && in1_data[SOP_BIT];
    // On a tie the port that did not win last time goes next.
    grant_port = (elig0 && elig1) ? !last_grant : elig1;
    if (rst && space) begin
      case (state)
        IDLE: begin
          if (elig0 || elig1) begin
            xfer     = 1'b1;
            sel_port = grant_port;
          end else if (in0_valid) begin
            stray0 = 1'b1;
          end else if (in1_valid) begin
            stray1 = 1'b1;
          end
        end
        FWD0: xfer = in0_valid;
        FWD1: begin
          xfer     = in1_valid;
          sel_port = 1'b1;
        end
        default: ;
      endcase
    end
    sel_data = sel_port ? in1_data : in0_data;
    in0_deq  = (xfer && !sel_port) || stray0;
    in1_deq  = (xfer && sel_port) || stray1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      err_stray  <= 1'b0;
    end else begin
      if (xfer) begin
        out_data  <= sel_data;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (stray0 || stray1) err_stray <= 1'b1;
      if (xfer) begin
        if (state == IDLE) begin
          last_grant <= sel_port;
          if (!sel_data[EOP_BIT]) state <= sel_port ? FWD1 : FWD0;
        end else begin
          if (sel_data[SOP_BIT]) err_stray <= 1'b1;
          if (sel_data[EOP_BIT]) state <= IDLE;
        end
      end
    end
  end

`ifdef PKT_MERGE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      pkt_cnt0  <= '0;
      pkt_cnt1  <= '0;
      stray_cnt <= '0;
    end else begin
      if (xfer && !sel_port && sel_data[EOP_BIT] && pkt_cnt0 != 16'hFFFF)
        pkt_cnt0 <= pkt_cnt0 + 16'd1;
      if (xfer && sel_port && sel_data[EOP_BIT] && pkt_cnt1 != 16'hFFFF)
        pkt_cnt1 <= pkt_cnt1 + 16'd1;
      if ((stray0 || stray1) && stray_cnt != 16'hFFFF)
        stray_cnt <= stray_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/pkt_merge_arb.md
Name: pkt_merge_arb

Overview:
- Drain side of the packet-merge input FIFOs.
- Dequeues 153-bit words from two input FIFOs (port 0, port 1) and merges them onto a single output stream.
- Packets are never interleaved: arbitration is round-robin at packet granularity.
- Sits between the two per-port input FIFOs and the merged output port, behind a one-entry registered output stage.

Parameters:
DW, 153, word width (all data buses)
SOP_BIT, 152, bit index of start-of-packet flag within a word
EOP_BIT, 151, bit index of end-of-packet flag within a word

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low
in0_data  input  DW  head word of port-0 FIFO, valid when in0_valid=1
in0_valid  input  1  port-0 FIFO not empty
in0_deq  output  1  pop port-0 FIFO this cycle
in1_data  input  DW  head word of port-1 FIFO
in1_valid  input  1  port-1 FIFO not empty
in1_deq  output  1  pop port-1 FIFO this cycle
out_data  output  DW  merged output word (registered)
out_valid  output  1  out_data holds a word
out_ready  input  1  downstream accepts out_data this cycle
err_stray  output  1  sticky: a non-SOP word was found at a head while idle

Behaviour:
- All state updates on posedge clk.
- rst=0 (synchronous) forces:
  - state=IDLE, out_valid=0, out_data=0, err_stray=0, last_grant=1 (port 0 wins the first tie).
  - in0_deq and in1_deq are held 0 for that cycle.
- Output stage:
  - space = !out_valid | out_ready.
  - A transfer occurs when space=1 and the selected port's valid=1.
  - On a transfer: out_data <= head word, out_valid <= 1, and the selected port's deq=1 (combinational, same cycle).
  - Otherwise, if out_ready=1, out_valid <= 0.
  - Latency: deq cycle N gives out_valid in cycle N+1.
  - Full throughput: 1 word/cycle when out_ready is held at 1.
- Deq rules:
  - inX_deq=1 only if inX_valid=1.
  - in0_deq and in1_deq are never both 1.
  - No deq while space=0.
- States IDLE, FWD0, FWD1.
- IDLE:
  - A port is eligible if valid=1 and data[SOP_BIT]=1.
  - One eligible port: grant it.
  - Both eligible: grant !last_grant.
  - The SOP word transfers in the same cycle as the grant (no arbitration bubble), and last_grant <= granted port.
  - After the grant: go to FWDx unless the word has EOP_BIT=1 (single-word packet), in which case stay in IDLE.
  - If space=0, no grant is made and the state is held.
- Stray words in IDLE:
  - A head word with valid=1 and SOP_BIT=0 at a non-granted port is dequeued and discarded (not forwarded), and err_stray <= 1.
  - Only one deq per cycle: a stray pop happens only in a cycle with no grant and space=1, port 0 checked first.
- FWDx:
  - Forwards only port x; the other port is ignored.
  - Word transferred with EOP_BIT=1: go to IDLE.
  - A word with SOP_BIT=1 mid-packet is forwarded unchanged and err_stray <= 1.
  - If inX_valid=0, wait in FWDx (bubble on output); no timeout.
- err_stray clears only on reset.
- Reset mid-packet:
  - The packet is abandoned and out_valid drops next edge.
  - Remaining body words in the FIFO later appear as stray words and are discarded.
- out_data holds its value when not updated.
- The block never writes, so input FIFO full status is not its concern.

Optional Feature:
- Macro PKT_MERGE_STATS_EN.
- When defined, adds outputs:
  - pkt_cnt0 [15:0], pkt_cnt1 [15:0]: increment on each EOP word transferred from that port.
  - stray_cnt [15:0]: increments per discarded stray word.
  - All three saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Single-packet path: reset; port0 presents 3 words (SOP, body, EOP), out_ready=1 → in0_deq high cycles 1-3, out_valid cycles 2-4 with identical data, state back to IDLE, err_stray=0.
- Tie-break: both ports present 2-word packets simultaneously after reset → port0 packet forwarded first, then port1 with zero idle cycles between; repeat → order port0, port1 again.
- Backpressure: out_ready=0 for 4 cycles mid-packet → out_data/out_valid stable, no deq asserted; on release, words resume in order with none lost or duplicated.
- Single-word packet: SOP=EOP=1 words on port1 each cycle, out_ready=1 → one word per cycle on output, state stays IDLE.
- Stray word: port0 head = word with SOP=0 in IDLE → in0_deq=1 one cycle, out_valid stays 0, err_stray=1 and stays 1.
- Starvation/mid-packet gap: port1 goes empty mid-packet while port0 holds a full packet → port0 not granted until port1's EOP arrives and transfers; with PKT_MERGE_STATS_EN, pkt_cnt1 increments by 1, then pkt_cnt0 by 1.
